// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the LSU MEM stage: funct3 codes, write-back selects,
// FSM states, pipeline-register structs and access-size helpers.
package lsu_mem_stage_pkg;

    localparam logic [2:0] MEM_OP_B  = 3'b000;
    localparam logic [2:0] MEM_OP_H  = 3'b001;
    localparam logic [2:0] MEM_OP_W  = 3'b010;
    localparam logic [2:0] MEM_OP_BU = 3'b100;
    localparam logic [2:0] MEM_OP_HU = 3'b101;

    localparam logic [1:0] WB_SEL_PC_4 = 2'b00;
    localparam logic [1:0] WB_SEL_ALU  = 2'b01;
    localparam logic [1:0] WB_SEL_MEM  = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_RESP = 2'b10
    } lsu_state_t;

    typedef struct packed {
        logic        valid;
        logic        reg_wen;
        logic [4:0]  reg_waddr;
        logic [1:0]  wb_sel;
        logic [31:0] alu_out;
        logic [31:0] mem_out;
        logic [31:0] pc_4;
        logic        misalign;
    } type_mem_wb_reg;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic        ren;
        logic        wen;
        logic [2:0]  op;
        logic        reg_wen;
        logic [4:0]  reg_waddr;
        logic [1:0]  wb_sel;
        logic [31:0] pc_4;
    } type_lsu_req;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MEM_OP_H, MEM_OP_HU: return off[0];
            MEM_OP_W:            return off != 2'b00;
            default:             return 1'b0;
        endcase
    endfunction

    // Offending low address bits are dropped so the access stays inside one word.
    function automatic logic [1:0] eff_offset(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MEM_OP_H, MEM_OP_HU: return {off[1], 1'b0};
            MEM_OP_W:            return 2'b00;
            default:             return off;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MEM_OP_B, MEM_OP_BU: return 4'b0001 << off;
            MEM_OP_H, MEM_OP_HU: return 4'b0011 << {off[1], 1'b0};
            default:             return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Load formatter: picks the byte/half lane from a read word and extends it.
module lsu_load_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  mem_op_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{offset_i, 3'b000} +: 8];
        half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (mem_op_i)
            MEM_OP_B:  data_o = {{24{byte_v[7]}}, byte_v};
            MEM_OP_BU: data_o = {24'h000000, byte_v};
            MEM_OP_H:  data_o = {{16{half_v[15]}}, half_v};
            MEM_OP_HU: data_o = {16'h0000, half_v};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage: runs loads/stores over a valid/ready data bus and fills the MEM/WB register.
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses skip the bus and flag wb_misalign.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_alu_out,
    input  logic [DATA_WIDTH-1:0]     in_store_data,
    input  logic                      in_mem_ren,
    input  logic                      in_mem_wen,
    input  logic [2:0]                in_mem_op,
    input  logic                      in_reg_wen,
    input  logic [REG_ADDR_WIDTH-1:0] in_reg_waddr,
    input  logic [1:0]                in_reg_wb_sel,
    input  logic [DATA_WIDTH-1:0]     in_pc_4,
    output logic                      dmem_req_valid,
    input  logic                      dmem_req_ready,
    output logic                      dmem_req_wen,
    output logic [ADDR_WIDTH-1:0]     dmem_req_addr,
    output logic [DATA_WIDTH-1:0]     dmem_req_wdata,
    output logic [3:0]                dmem_req_wstrb,
    input  logic                      dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     dmem_resp_rdata,
    output logic                      wb_valid,
    output logic                      wb_reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_waddr,
    output logic [1:0]                wb_reg_wb_sel,
    output logic [DATA_WIDTH-1:0]     wb_alu_out,
    output logic [DATA_WIDTH-1:0]     wb_mem_out,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                      wb_misalign,
`endif
    output logic [DATA_WIDTH-1:0]     wb_pc_4
);

    lsu_state_t     state_q, state_d;
    type_lsu_req    req_q, req_d;
    type_mem_wb_reg wb_q, wb_d;

    logic [1:0]  req_off;
    logic [31:0] load_data;
    logic        in_is_mem;
    logic        in_trap;

    assign req_off = eff_offset(req_q.op, req_q.alu_out[1:0]);

    lsu_load_align u_load_align (
        .rdata_i  (dmem_resp_rdata),
        .offset_i (req_off),
        .mem_op_i (req_q.op),
        .data_o   (load_data)
    );

    assign in_ready  = (state_q == LSU_IDLE);
    assign in_is_mem = in_mem_ren | in_mem_wen;

`ifdef LSU_MISALIGN_TRAP_EN
    assign in_trap = in_is_mem & is_misaligned(in_mem_op, in_alu_out[1:0]);
`else
    assign in_trap = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        wb_d           = wb_q;
        wb_d.valid     = 1'b0;
        wb_d.reg_wen   = 1'b0;
        wb_d.misalign  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (in_valid) begin
                    if (in_is_mem && !in_trap) begin
                        req_d.alu_out    = in_alu_out;
                        req_d.store_data = in_store_data;
                        req_d.ren        = in_mem_ren;
                        req_d.wen        = in_mem_wen;
                        req_d.op         = in_mem_op;
                        req_d.reg_wen    = in_reg_wen;
                        req_d.reg_waddr  = in_reg_waddr;
                        req_d.wb_sel     = in_reg_wb_sel;
                        req_d.pc_4       = in_pc_4;
                        state_d          = LSU_REQ;
                    end else begin
                        // Pass-through and trapped accesses retire straight from IDLE.
                        wb_d.valid     = 1'b1;
                        wb_d.reg_wen   = in_reg_wen & ~in_trap;
                        wb_d.reg_waddr = in_reg_waddr;
                        wb_d.wb_sel    = in_reg_wb_sel;
                        wb_d.alu_out   = in_alu_out;
                        wb_d.mem_out   = '0;
                        wb_d.pc_4      = in_pc_4;
                        wb_d.misalign  = in_trap;
                    end
                end
            end
            LSU_REQ: begin
                if (dmem_req_ready) begin
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                if (dmem_resp_valid) begin
                    wb_d.valid     = 1'b1;
                    wb_d.reg_wen   = req_q.reg_wen;
                    wb_d.reg_waddr = req_q.reg_waddr;
                    wb_d.wb_sel    = req_q.wb_sel;
                    wb_d.alu_out   = req_q.alu_out;
                    wb_d.mem_out   = req_q.ren ? load_data : '0;
                    wb_d.pc_4      = req_q.pc_4;
                    state_d        = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            req_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        dmem_req_wdata = '0;
        dmem_req_wstrb = 4'b0000;
        if (req_q.wen) begin
            dmem_req_wstrb = store_strb(req_q.op, req_off);
            case (req_q.op)
                MEM_OP_B, MEM_OP_BU: dmem_req_wdata = {4{req_q.store_data[7:0]}};
                MEM_OP_H, MEM_OP_HU: dmem_req_wdata = {2{req_q.store_data[15:0]}};
                default:             dmem_req_wdata = req_q.store_data;
            endcase
        end
    end

    assign dmem_req_valid = (state_q == LSU_REQ);
    assign dmem_req_wen   = req_q.wen;
    assign dmem_req_addr  = {req_q.alu_out[ADDR_WIDTH-1:2], 2'b00};

    assign wb_valid      = wb_q.valid;
    assign wb_reg_wen    = wb_q.valid & wb_q.reg_wen & ~wb_q.misalign;
    assign wb_reg_waddr  = wb_q.reg_waddr;
    assign wb_reg_wb_sel = wb_q.wb_sel;
    assign wb_alu_out    = wb_q.alu_out;
    assign wb_mem_out    = wb_q.mem_out;
    assign wb_pc_4       = wb_q.pc_4;
`ifdef LSU_MISALIGN_TRAP_EN
    assign wb_misalign   = wb_q.misalign;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus random loads/stores/ALU ops.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_out;
    logic [31:0] in_store_data;
    logic        in_mem_ren;
    logic        in_mem_wen;
    logic [2:0]  in_mem_op;
    logic        in_reg_wen;
    logic [4:0]  in_reg_waddr;
    logic [1:0]  in_reg_wb_sel;
    logic [31:0] in_pc_4;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_wen;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        wb_valid;
    logic        wb_reg_wen;
    logic [4:0]  wb_reg_waddr;
    logic [1:0]  wb_reg_wb_sel;
    logic [31:0] wb_alu_out;
    logic [31:0] wb_mem_out;
    logic [31:0] wb_pc_4;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        wb_misalign;
`endif

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_alu_out      (in_alu_out),
        .in_store_data   (in_store_data),
        .in_mem_ren      (in_mem_ren),
        .in_mem_wen      (in_mem_wen),
        .in_mem_op       (in_mem_op),
        .in_reg_wen      (in_reg_wen),
        .in_reg_waddr    (in_reg_waddr),
        .in_reg_wb_sel   (in_reg_wb_sel),
        .in_pc_4         (in_pc_4),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_wen    (dmem_req_wen),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .wb_valid        (wb_valid),
        .wb_reg_wen      (wb_reg_wen),
        .wb_reg_waddr    (wb_reg_waddr),
        .wb_reg_wb_sel   (wb_reg_wb_sel),
        .wb_alu_out      (wb_alu_out),
        .wb_mem_out      (wb_mem_out),
`ifdef LSU_MISALIGN_TRAP_EN
        .wb_misalign     (wb_misalign),
`endif
        .wb_pc_4         (wb_pc_4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: access size in bytes from funct3, low-bit dropping, lane shifts.
    function automatic int unsigned op_size(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] size_mask(input int unsigned size);
        if (size == 4) return 32'hFFFF_FFFF;
        return (32'd1 << (8 * size)) - 32'd1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int unsigned eff,
                                             input logic [2:0] op);
        int unsigned size;
        logic [31:0] mask;
        logic [31:0] v;
        size = op_size(op);
        mask = size_mask(size);
        v = (rdata >> (8 * eff)) & mask;
        if (!op[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] sdata,
                          input logic ren, input logic wen, input logic [2:0] op,
                          input logic rwen, input logic [4:0] waddr, input logic [1:0] sel,
                          input logic [31:0] pc4, input logic [31:0] rdata,
                          input int unsigned rdy_dly, input int unsigned resp_dly);
        int unsigned size, off, eff;
        logic        mem, mis, trap;
        logic [31:0] e_strb, e_wdata, e_addr;
        size = op_size(op);
        off  = alu % 4;
        mem  = ren | wen;
        mis  = mem && ((off % size) != 0);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = mis;
`else
        trap = 1'b0;
`endif
        eff    = off - (off % size);
        e_addr = alu - off;
        e_strb = wen ? (((32'd1 << size) - 32'd1) << eff) : 32'd0;
        if (!wen)           e_wdata = 32'd0;
        else if (size == 1) e_wdata = {24'd0, sdata[7:0]} * 32'h0101_0101;
        else if (size == 2) e_wdata = {16'd0, sdata[15:0]} * 32'h0001_0001;
        else                e_wdata = sdata;

        in_alu_out = alu; in_store_data = sdata; in_mem_ren = ren; in_mem_wen = wen;
        in_mem_op = op; in_reg_wen = rwen; in_reg_waddr = waddr; in_reg_wb_sel = sel;
        in_pc_4 = pc4; in_valid = 1'b1;
        chk({tag, ".accept_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        if (!mem || trap) begin
            chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
            chk({tag, ".reg_wen"}, 32'(wb_reg_wen), 32'(rwen & ~trap));
            chk({tag, ".waddr"}, 32'(wb_reg_waddr), 32'(waddr));
            chk({tag, ".alu"}, wb_alu_out, alu);
            chk({tag, ".pc4"}, wb_pc_4, pc4);
            chk({tag, ".memout"}, wb_mem_out, 32'd0);
            chk({tag, ".no_req"}, 32'(dmem_req_valid), 32'd0);
            chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
            chk({tag, ".misalign"}, 32'(wb_misalign), 32'(trap));
`endif
        end else begin
            chk({tag, ".bubble"}, 32'(wb_valid), 32'd0);
            for (int unsigned i = 0; i <= rdy_dly; i++) begin
                chk({tag, ".req_valid"}, 32'(dmem_req_valid), 32'd1);
                chk({tag, ".req_addr"}, dmem_req_addr, e_addr);
                chk({tag, ".req_wen"}, 32'(dmem_req_wen), 32'(wen));
                chk({tag, ".req_wstrb"}, 32'(dmem_req_wstrb), e_strb);
                chk({tag, ".req_wdata"}, dmem_req_wdata, e_wdata);
                chk({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
                if (i == rdy_dly) dmem_req_ready = 1'b1;
                tick();
            end
            dmem_req_ready = 1'b0;
            for (int unsigned i = 0; i <= resp_dly; i++) begin
                chk({tag, ".resp_reqv"}, 32'(dmem_req_valid), 32'd0);
                chk({tag, ".resp_wbv"}, 32'(wb_valid), 32'd0);
                chk({tag, ".resp_ready"}, 32'(in_ready), 32'd0);
                if (i == resp_dly) begin
                    dmem_resp_valid = 1'b1;
                    dmem_resp_rdata = rdata;
                end
                tick();
            end
            dmem_resp_valid = 1'b0;
            dmem_resp_rdata = 32'hDEAD_BEEF;
            chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
            chk({tag, ".reg_wen"}, 32'(wb_reg_wen), 32'(rwen));
            chk({tag, ".waddr"}, 32'(wb_reg_waddr), 32'(waddr));
            chk({tag, ".sel"}, 32'(wb_reg_wb_sel), 32'(sel));
            chk({tag, ".alu"}, wb_alu_out, alu);
            chk({tag, ".pc4"}, wb_pc_4, pc4);
            chk({tag, ".memout"}, wb_mem_out, ren ? ref_load(rdata, eff, op) : 32'd0);
            chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [2:0]  load_ops [5];
        int unsigned kind;
        load_ops[0] = 3'b000; load_ops[1] = 3'b001; load_ops[2] = 3'b010;
        load_ops[3] = 3'b100; load_ops[4] = 3'b101;

        rst = 1'b1; in_valid = 1'b0; in_alu_out = '0; in_store_data = '0;
        in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_mem_op = '0; in_reg_wen = 1'b0;
        in_reg_waddr = '0; in_reg_wb_sel = '0; in_pc_4 = '0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_reg_wen", 32'(wb_reg_wen), 32'd0);
        chk("rst.wb_alu", wb_alu_out, 32'd0);
        chk("rst.wb_mem", wb_mem_out, 32'd0);
        chk("rst.req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op("alu", 32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 2'b01, 32'h0000_0104,
               32'h0, 0, 0);
        tick();
        chk("alu.bubble_valid", 32'(wb_valid), 32'd0);
        chk("alu.bubble_wen", 32'(wb_reg_wen), 32'd0);

        run_op("lb", 32'h0000_1003, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 5'd7, 2'b10, 32'h0000_0200,
               32'h80FF_FFFF, 0, 0);
        chk("lb.const", wb_mem_out, 32'hFFFF_FF80);
        run_op("lhu", 32'h0000_2002, 32'h0, 1'b1, 1'b0, 3'b101, 1'b1, 5'd8, 2'b10, 32'h0000_0204,
               32'hBEEF_0000, 0, 1);
        chk("lhu.const", wb_mem_out, 32'h0000_BEEF);
        run_op("lh", 32'h0000_2002, 32'h0, 1'b1, 1'b0, 3'b001, 1'b1, 5'd9, 2'b10, 32'h0000_0208,
               32'hBEEF_0000, 1, 0);
        chk("lh.const", wb_mem_out, 32'hFFFF_BEEF);
        run_op("sb", 32'h0000_3001, 32'h0000_00AB, 1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 2'b01,
               32'h0000_020C, 32'h0, 4, 0);
        run_op("lw_mis", 32'h0000_4002, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd10, 2'b10,
               32'h0000_0210, 32'h1234_5678, 0, 0);

        // Reset while a load waits for its response.
        in_alu_out = 32'h0000_5000; in_mem_ren = 1'b1; in_mem_wen = 1'b0; in_mem_op = 3'b010;
        in_reg_wen = 1'b1; in_reg_waddr = 5'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("rstmid.in_resp", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rstmid.req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rstmid.wb_valid", 32'(wb_valid), 32'd0);
        chk("rstmid.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_op("alu_post", 32'h0000_0ABC, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd12, 2'b01,
               32'h0000_0300, 32'h0, 0, 0);

        for (int unsigned n = 0; n < 40; n++) begin
            kind = $urandom_range(2, 0);
            if (kind == 0) begin
                run_op("rnd_alu", $urandom, $urandom, 1'b0, 1'b0, 3'($urandom_range(7, 0)),
                       1'($urandom), 5'($urandom), 2'($urandom), $urandom, 32'h0, 0, 0);
            end else if (kind == 1) begin
                rop = load_ops[$urandom_range(4, 0)];
                run_op("rnd_ld", $urandom, $urandom, 1'b1, 1'b0, rop, 1'($urandom),
                       5'($urandom), 2'b10, $urandom, $urandom,
                       $urandom_range(2, 0), $urandom_range(2, 0));
            end else begin
                rop = 3'($urandom_range(2, 0));
                run_op("rnd_st", $urandom, $urandom, 1'b0, 1'b1, rop, 1'b0,
                       5'($urandom), 2'b01, $urandom, $urandom,
                       $urandom_range(2, 0), $urandom_range(2, 0));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
MEM pipeline stage that sits directly upstream of the write-back unit. It accepts one EX-stage result at a time and performs loads and stores over a valid/ready data-memory bus. Loads get byte-lane extraction and sign/zero extension. Results are registered into the MEM/WB pipeline register consumed by write-back. Non-memory instructions pass through with one-cycle latency; the stage stalls upstream while a bus transaction is outstanding.

Parameters:
DATA_WIDTH, 32, datapath and bus data width (only 32 supported)
ADDR_WIDTH, 32, byte address width
REG_ADDR_WIDTH, 5, register-file index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  EX result valid
in_ready  out  1  stage can accept (state==IDLE)
in_alu_out  in  DATA_WIDTH  ALU result / effective address
in_store_data  in  DATA_WIDTH  rs2 value for stores
in_mem_ren  in  1  load
in_mem_wen  in  1  store (never both with ren)
in_mem_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_reg_wen  in  1  register write enable
in_reg_waddr  in  REG_ADDR_WIDTH  destination register
in_reg_wb_sel  in  2  write-back select (PC_4 / ALU / MEM encodings)
in_pc_4  in  DATA_WIDTH  PC+4
dmem_req_valid  out  1  bus request valid
dmem_req_ready  in  1  bus accepts request
dmem_req_wen  out  1  1=write, 0=read
dmem_req_addr  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}
dmem_req_wdata  out  DATA_WIDTH  lane-replicated store data
dmem_req_wstrb  out  4  byte strobes
dmem_resp_valid  in  1  response/ack valid (always accepted)
dmem_resp_rdata  in  DATA_WIDTH  read word
wb_valid  out  1  MEM/WB register holds a valid instruction
wb_reg_wen, wb_reg_waddr, wb_reg_wb_sel, wb_alu_out, wb_mem_out, wb_pc_4  out  (widths as inputs; wb_mem_out DATA_WIDTH)  MEM/WB register fields

Behaviour:
- Reset: state=IDLE; every wb_* output 0; dmem_req_valid=0; all latched fields 0. A reset mid-transaction drops dmem_req_valid immediately and abandons the transaction; the bus tolerates this.
- FSM states are IDLE, REQ and RESP.
- IDLE, accept (in_valid&in_ready) of a non-memory instruction: the wb_* fields are loaded at the next edge and wb_valid=1 for that cycle. Latency is 1. The stage stays in IDLE.
- IDLE, accept of a load or store: the instruction fields are latched and the state moves to REQ. wb_valid=0 on the next edge (bubble).
- REQ: dmem_req_valid=1. Address, wen, wdata and wstrb are held stable until dmem_req_ready. On that handshake the state moves to RESP and dmem_req_valid=0 at the next edge. dmem_resp_valid is ignored in REQ.
- RESP: wait for dmem_resp_valid; stores also wait for it (write ack). On response, wb_* is loaded, wb_valid=1 for one cycle, and the state returns to IDLE.
- Best-case memory-op timing: accept at T, request at T+1, ready at T+1, response at T+2, wb_valid at T+3.
- in_ready=0 in REQ and RESP. Upstream holds its inputs stable while stalled.
- wb_valid=0 forces wb_reg_wen=0. Every cycle without a loaded instruction is a bubble.
- Load formatting by addr[1:0]:
  - B/BU: select byte lane, then sign- or zero-extend.
  - H/HU: select half lane addr[1], then extend.
  - W: whole word.
  - Non-load: wb_mem_out=0.
- Stores:
  - SB: wstrb=0001<<addr[1:0], byte replicated ×4.
  - SH: wstrb=0011<<{addr[1],1'b0}, half replicated ×2.
  - SW: wstrb=1111.
  - Reads: wstrb=0000.
- Misalignment is a halfword with addr[0]=1 or a word with addr[1:0]≠0. Its handling is set by the macro below.

Optional Feature:
LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no bus request. It goes IDLE→wb directly with 1-cycle latency, wb_reg_wen=0, and an extra output wb_misalign=1 (1 bit, reset 0) for that instruction.
- Undefined: the wb_misalign port is absent. The low offending address bits are treated as 0 (half→addr[1],0; word→00) and the access proceeds normally.

Decomposition:
- Shared package holds:
  - mem_op funct3 constants.
  - reg_wb_sel encodings.
  - The lsu_state_t enum.
  - A type_mem_wb_reg struct bundling the wb_* fields so the write-back stage can consume it as one port.
- One natural sub-module: lsu_load_align, purely combinational (rdata, addr[1:0], mem_op → formatted data). It is unit-testable alone.

Test Plan:
- ALU op, in_alu_out=0x1234, wb_sel=ALU, waddr=5 → next cycle wb_valid=1, wb_alu_out=0x1234, wb_reg_waddr=5, in_ready stays 1.
- LB addr=0x1003, rdata=0x80FF_FFFF, ready at first REQ cycle, resp one cycle later → wb_mem_out=0xFFFF_FF80, wb_valid exactly 3 cycles after accept.
- LHU addr=0x2002, rdata=0xBEEF_0000 → wb_mem_out=0x0000_BEEF. LH on the same data → 0xFFFF_BEEF.
- SB addr=0x3001, data=0xAB → dmem_req_addr=0x3000, wstrb=0010, wdata=0xABAB_ABAB. Hold dmem_req_ready=0 for 4 cycles → request fields stable, in_ready=0 throughout.
- Assert rst while in RESP → dmem_req_valid=0, wb_valid=0, in_ready=1 right after reset. A new ALU op then completes normally.
- With LSU_MISALIGN_TRAP_EN, LW addr=0x4002 → no dmem_req_valid, next cycle wb_valid=1, wb_misalign=1, wb_reg_wen=0. Without the macro → request at 0x4000 and a normal load.
